// File: rtl/fb_write_sched.sv
// Framebuffer write-port scheduler: full-screen clear after reset or on request,
// then round-robin sharing of the write port between the brush and host requesters.
module fb_write_sched #(
  parameter int                 WIDTH       = 640,
  parameter int                 HEIGHT      = 480,
  parameter int                 ADDR_W      = 20,
  parameter int                 DATA_W      = 9,
  parameter logic [DATA_W-1:0]  RESET_COLOR = 9'h1FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_color,
  input  logic              brush_valid,
  output logic              brush_ready,
  input  logic [ADDR_W-1:0] brush_addr,
  input  logic [DATA_W-1:0] brush_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              clear_busy,
  output logic              initialized,
  output logic              addr_err
);

  localparam int                PIXELS    = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] PIX_END   = ADDR_W'(PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_ARB   = 1'b1;

  localparam logic LAST_BRUSH = 1'b0;
  localparam logic LAST_HOST  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              init_q, init_d;
  logic              err_q, err_d;
  logic              brush_rdy, host_rdy;
  logic              brush_xfer, host_xfer;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a < PIX_END;
  endfunction

  // A pending clear request pre-empts both requesters for its whole cycle.
  always_comb begin
    brush_rdy = 1'b0;
    host_rdy  = 1'b0;
    if (state_q == ST_ARB && !clear_req) begin
      brush_rdy = brush_valid && (!host_valid || last_q == LAST_HOST);
      host_rdy  = host_valid && (!brush_valid || last_q == LAST_BRUSH);
    end
  end

  assign brush_xfer = brush_valid & brush_rdy;
  assign host_xfer  = host_valid & host_rdy;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    color_d = color_q;
    last_d  = last_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    init_d  = init_q;
    err_d   = err_q;
    if (state_q == ST_CLEAR) begin
      we_d   = 1'b1;
      addr_d = count_q;
      data_d = color_q;
      if (count_q == LAST_ADDR) begin
        state_d = ST_ARB;
        count_d = '0;
        init_d  = 1'b1;
      end else begin
        count_d = count_q + ADDR_W'(1);
      end
    end else if (clear_req) begin
      state_d = ST_CLEAR;
      count_d = '0;
      color_d = clear_color;
    end else if (brush_xfer) begin
      last_d = LAST_BRUSH;
      if (in_range(brush_addr)) begin
        we_d   = 1'b1;
        addr_d = brush_addr;
        data_d = brush_data;
      end else begin
        err_d = 1'b1;
      end
    end else if (host_xfer) begin
      last_d = LAST_HOST;
      if (in_range(host_addr)) begin
        we_d   = 1'b1;
        addr_d = host_addr;
        data_d = host_data;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Registered write port: one cycle from handshake to RAM write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      count_q <= '0;
      color_q <= RESET_COLOR;
      last_q  <= LAST_HOST;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      init_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      color_q <= color_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      init_q  <= init_d;
      err_q   <= err_d;
    end
  end

  assign brush_ready = brush_rdy;
  assign host_ready  = host_rdy;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign clear_busy  = (state_q == ST_CLEAR);
  assign initialized = init_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched on an 8x4 screen: clear sequencing,
// arbitration vectors, out-of-range drops, clear pre-emption and mid-clear reset.
module tb_fb_write_sched;

  localparam int AW = 20;
  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_req;
  logic [DW-1:0] clear_color;
  logic          brush_valid, brush_ready;
  logic [AW-1:0] brush_addr;
  logic [DW-1:0] brush_data;
  logic          host_valid, host_ready;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          clear_busy, initialized, addr_err;

  int checks = 0;
  int failures = 0;

  fb_write_sched #(
    .WIDTH(8), .HEIGHT(4), .ADDR_W(AW), .DATA_W(DW), .RESET_COLOR(9'h1FF)
  ) dut (
    .clk(clk), .reset(reset),
    .clear_req(clear_req), .clear_color(clear_color),
    .brush_valid(brush_valid), .brush_ready(brush_ready),
    .brush_addr(brush_addr), .brush_data(brush_data),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_data(host_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .clear_busy(clear_busy), .initialized(initialized), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          hv;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic          e_br;
    logic          e_hr;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_err;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Expects the next 32 cycles to carry the clear writes for addresses 0..31.
  task automatic run_clear(input logic [DW-1:0] col, input int pulse_at, input logic exp_init);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      chk("clr_we", 32'(mem_we), 32'd1);
      chk("clr_addr", 32'(mem_addr), 32'(i));
      chk("clr_data", 32'(mem_data), 32'(col));
      if (i < 31) begin
        chk("clr_busy", 32'(clear_busy), 32'd1);
        chk("clr_init", 32'(initialized), 32'(exp_init));
        if (i == pulse_at) begin
          clear_req   = 1'b1;
          clear_color = 9'h1F0;
        end else begin
          clear_req = 1'b0;
        end
        #1;
        chk("clr_bready", 32'(brush_ready), 32'd0);
        chk("clr_hready", 32'(host_ready), 32'd0);
      end
    end
  endtask

  initial begin
    vec[0]  = '{1'b1, 20'd5,  9'h1A3, 1'b0, 20'd0,  9'h000, 1'b1, 1'b0, 1'b1, 20'd5,  9'h1A3, 1'b0};
    vec[1]  = '{1'b0, 20'd0,  9'h000, 1'b1, 20'd3,  9'h033, 1'b0, 1'b1, 1'b1, 20'd3,  9'h033, 1'b0};
    vec[2]  = '{1'b1, 20'd1,  9'h011, 1'b1, 20'd2,  9'h022, 1'b1, 1'b0, 1'b1, 20'd1,  9'h011, 1'b0};
    vec[3]  = '{1'b1, 20'd1,  9'h011, 1'b1, 20'd2,  9'h022, 1'b0, 1'b1, 1'b1, 20'd2,  9'h022, 1'b0};
    vec[4]  = '{1'b1, 20'd1,  9'h011, 1'b1, 20'd2,  9'h022, 1'b1, 1'b0, 1'b1, 20'd1,  9'h011, 1'b0};
    vec[5]  = '{1'b1, 20'd1,  9'h011, 1'b1, 20'd2,  9'h022, 1'b0, 1'b1, 1'b1, 20'd2,  9'h022, 1'b0};
    vec[6]  = '{1'b0, 20'd0,  9'h000, 1'b0, 20'd0,  9'h000, 1'b0, 1'b0, 1'b0, 20'd0,  9'h000, 1'b0};
    vec[7]  = '{1'b0, 20'd0,  9'h000, 1'b1, 20'd32, 9'h155, 1'b0, 1'b1, 1'b0, 20'd0,  9'h000, 1'b1};
    vec[8]  = '{1'b0, 20'd0,  9'h000, 1'b0, 20'd0,  9'h000, 1'b0, 1'b0, 1'b0, 20'd0,  9'h000, 1'b1};
    vec[9]  = '{1'b1, 20'd31, 9'h0AA, 1'b0, 20'd0,  9'h000, 1'b1, 1'b0, 1'b1, 20'd31, 9'h0AA, 1'b1};
    vec[10] = '{1'b1, 20'd0,  9'h0BB, 1'b1, 20'd4,  9'h044, 1'b0, 1'b1, 1'b1, 20'd4,  9'h044, 1'b1};
    vec[11] = '{1'b1, 20'd0,  9'h0BB, 1'b0, 20'd0,  9'h000, 1'b1, 1'b0, 1'b1, 20'd0,  9'h0BB, 1'b1};
    vec[12] = '{1'b1, 20'hFFFFF, 9'h001, 1'b0, 20'd0, 9'h000, 1'b1, 1'b0, 1'b0, 20'd0, 9'h000, 1'b1};

    reset = 1'b1; clear_req = 1'b0; clear_color = '0;
    brush_valid = 1'b0; brush_addr = '0; brush_data = '0;
    host_valid = 1'b0; host_addr = '0; host_data = '0;

    // Reset state, with both requesters pushing to prove the readies are gated.
    repeat (2) @(posedge clk);
    #1;
    brush_valid = 1'b1; brush_addr = 20'd7; brush_data = 9'h0F0;
    host_valid  = 1'b1; host_addr  = 20'd9; host_data  = 9'h00F;
    #1;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd1);
    chk("rst_init", 32'(initialized), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    chk("rst_bready", 32'(brush_ready), 32'd0);
    chk("rst_hready", 32'(host_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_clear(9'h1FF, -1, 1'b0);
    #1;
    chk("tie1_bready", 32'(brush_ready), 32'd1);
    chk("tie1_hready", 32'(host_ready), 32'd0);
    @(posedge clk); #1;
    chk("post_busy", 32'(clear_busy), 32'd0);
    chk("post_init", 32'(initialized), 32'd1);
    chk("tie1_we", 32'(mem_we), 32'd1);
    chk("tie1_addr", 32'(mem_addr), 32'd7);
    chk("tie1_data", 32'(mem_data), 32'h0F0);
    brush_valid = 1'b0;
    #1;
    chk("tie2_hready", 32'(host_ready), 32'd1);
    @(posedge clk); #1;
    chk("tie2_we", 32'(mem_we), 32'd1);
    chk("tie2_addr", 32'(mem_addr), 32'd9);
    chk("tie2_data", 32'(mem_data), 32'h00F);
    host_valid = 1'b0;

    // Arbitration vectors: readies checked same cycle, write checked next cycle.
    for (int k = 0; k <= 13; k++) begin
      @(posedge clk); #1;
      if (k > 0) begin
        chk($sformatf("v%0d_we", k-1), 32'(mem_we), 32'(vec[k-1].e_we));
        if (vec[k-1].e_we) begin
          chk($sformatf("v%0d_addr", k-1), 32'(mem_addr), 32'(vec[k-1].e_addr));
          chk($sformatf("v%0d_data", k-1), 32'(mem_data), 32'(vec[k-1].e_data));
        end
        chk($sformatf("v%0d_err", k-1), 32'(addr_err), 32'(vec[k-1].e_err));
      end
      if (k < 13) begin
        brush_valid = vec[k].bv; brush_addr = vec[k].ba; brush_data = vec[k].bd;
        host_valid  = vec[k].hv; host_addr  = vec[k].ha; host_data  = vec[k].hd;
        #1;
        chk($sformatf("v%0d_bready", k), 32'(brush_ready), 32'(vec[k].e_br));
        chk($sformatf("v%0d_hready", k), 32'(host_ready), 32'(vec[k].e_hr));
      end else begin
        brush_valid = 1'b0; host_valid = 1'b0;
      end
    end

    // Clear request collides with a brush request; brush waits out the clear.
    clear_req = 1'b1; clear_color = 9'h007;
    brush_valid = 1'b1; brush_addr = 20'd6; brush_data = 9'h1C0;
    #1;
    chk("creq_bready", 32'(brush_ready), 32'd0);
    chk("creq_hready", 32'(host_ready), 32'd0);
    @(posedge clk); #1;
    chk("creq1_we", 32'(mem_we), 32'd0);
    chk("creq1_busy", 32'(clear_busy), 32'd1);
    clear_req = 1'b0;
    #1;
    chk("creq1_bready", 32'(brush_ready), 32'd0);
    run_clear(9'h007, 10, 1'b1);
    #1;
    chk("after_clr_bready", 32'(brush_ready), 32'd1);
    @(posedge clk); #1;
    chk("after_clr_we", 32'(mem_we), 32'd1);
    chk("after_clr_addr", 32'(mem_addr), 32'd6);
    chk("after_clr_data", 32'(mem_data), 32'h1C0);
    chk("err_sticky", 32'(addr_err), 32'd1);
    brush_valid = 1'b0;

    // User clear interrupted by reset at count 10.
    @(posedge clk); #1;
    clear_req = 1'b1; clear_color = 9'h007;
    @(posedge clk); #1;
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("rc_addr", 32'(mem_addr), 32'(i));
      chk("rc_data", 32'(mem_data), 32'h007);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_init", 32'(initialized), 32'd0);
    chk("mid_rst_err", 32'(addr_err), 32'd0);
    chk("mid_rst_busy", 32'(clear_busy), 32'd1);
    reset = 1'b0;
    run_clear(9'h1FF, -1, 1'b0);
    @(posedge clk); #1;
    chk("end_we", 32'(mem_we), 32'd0);
    chk("end_busy", 32'(clear_busy), 32'd0);
    chk("end_init", 32'(initialized), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
